serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 104 ++++++++++
 tb/tb_serial_adder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit add/subtract with start/busy/done handshake (optional ovf via SERIAL_ADDER_OVF_EN)
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   s
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             sum_bit;
    logic             carry_next;
    logic             last_bit;
    logic             accept;

    // Single full-adder cell working on the LSBs of the operand shift registers
    assign sum_bit    = op_a[0] ^ op_b[0] ^ carry;
    assign carry_next = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
    assign last_bit   = (cnt == CW'(1));
    // DONE accepts a new start just like IDLE, so back-to-back ops cost WIDTH+1 cycles
    assign accept     = start && (state != RUN);

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start is ignored while RUN is in progress
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: state_next = start ? RUN : IDLE;
            RUN:        state_next = last_bit ? DONE : RUN;
            default:    state_next = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, shift one bit per RUN cycle, publish s on the last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s     <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (accept) begin
            // Subtraction is a + ~b + ~cin; the inverted borrow seeds the carry flop
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= cin ^ sub;
            cnt   <= CW'(WIDTH);
        end else if (state == RUN) begin
            op_a  <= op_a >> 1;
            op_b  <= op_b >> 1;
            carry <= carry_next;
            res   <= {sum_bit, res[WIDTH-1:1]};
            cnt   <= cnt - CW'(1);
            if (last_bit) begin
                s <= {carry_next, sum_bit, res[WIDTH-1:1]};
`ifdef SERIAL_ADDER_OVF_EN
                // On the MSB step, carry holds the carry into the MSB
                ovf <= carry ^ carry_next;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder with randomized and directed stimulus
module tb_serial_adder;

    localparam int W = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         cin   = 1'b0;
    logic         sub   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W:0]   s;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
    logic         ovf8;
`endif

    logic         start8 = 1'b0;
    logic [7:0]   a8     = '0;
    logic [7:0]   b8     = '0;
    logic         zero8  = 1'b0;
    logic         busy8;
    logic         done8;
    logic [8:0]   s8;

    serial_adder #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .s     (s)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (zero8),
        .sub   (zero8),
        .busy  (busy8),
        .done  (done8),
        .s     (s8)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf8)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int s;
        int v;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    int   rem      = 0;
    bit   exp_busy = 1'b0;
    bit   exp_done = 1'b0;
    int   last_s   = 0;
    int   last_v   = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations
    function automatic exp_t model(input int av, input int bv, input int c, input int sb);
        exp_t e;
        int   r;
        int   sr;
        int   sa;
        int   sbb;
        sa  = (av >= (1 << (W - 1))) ? av - (1 << W) : av;
        sbb = (bv >= (1 << (W - 1))) ? bv - (1 << W) : bv;
        if (sb == 0) begin
            r   = av + bv + c;
            e.s = r;
            sr  = sa + sbb + c;
        end else begin
            r   = av - bv - c;
            e.s = (r & ((1 << W) - 1)) | ((r >= 0) ? (1 << W) : 0);
            sr  = sa - sbb - c;
        end
        e.v = (sr > (1 << (W - 1)) - 1 || sr < -(1 << (W - 1))) ? 1 : 0;
        return e;
    endfunction

    // Monitor: check handshake against a cycle model, pop and compare on done, then predict next cycle
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            chk("busy", int'(busy), int'(exp_busy));
            chk("done", int'(done), int'(exp_done));
            if (exp_done && q.size() > 0) begin
                e      = q.pop_front();
                last_s = e.s;
                last_v = e.v;
            end
            chk("s", int'(s), last_s);
`ifdef SERIAL_ADDER_OVF_EN
            chk("ovf", int'(ovf), last_v);
`endif
            if (exp_busy) begin
                rem--;
                if (rem == 0) begin
                    exp_busy = 1'b0;
                    exp_done = 1'b1;
                end
            end else begin
                exp_done = 1'b0;
                if (start) begin
                    q.push_back(model(int'(a), int'(b), int'(cin), int'(sub)));
                    rem      = W;
                    exp_busy = 1'b1;
                end
            end
        end
    end

    task automatic op(input int av, input int bv, input int c, input int sb,
                      input string name, input int exp_s, input int exp_v);
        @(posedge clk); #2;
        a = W'(av); b = W'(bv); cin = c[0]; sub = sb[0]; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (W) @(posedge clk);
        #2;
        chk({name, "_done"}, int'(done), 1);
        chk({name, "_s"}, int'(s), exp_s);
`ifdef SERIAL_ADDER_OVF_EN
        if (exp_v >= 0) chk({name, "_ovf"}, int'(ovf), exp_v);
`else
        if (exp_v > 1) chk({name, "_v"}, exp_v, 0);
`endif
        @(posedge clk); #2;
        chk({name, "_hold"}, int'(s), exp_s);
    endtask

    initial begin
        int n;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_s", int'(s), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        op(5, 3, 0, 0, "add_5_3", 5'b01000, -1);
        op(15, 15, 1, 0, "add_max", 5'h1F, -1);
        op(3, 5, 0, 1, "sub_3_5", 5'b01110, -1);
        op(9, 4, 1, 1, "sub_9_4_b", 5'b10100, -1);
`ifdef SERIAL_ADDER_OVF_EN
        op(7, 1, 0, 0, "ovf_add", 5'b01000, 1);
        op(8, 1, 0, 1, "ovf_sub", 5'b10111, 1);
        op(2, 3, 0, 0, "no_ovf", 5'b00101, 0);
`endif

        // WIDTH=8: latency and full carry ripple
        @(posedge clk); #2;
        a8 = 8'hFF; b8 = 8'h01; start8 = 1'b1;
        @(posedge clk); #2;
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        chk("w8_latency", n, 8);
        chk("w8_s", int'(s8), 9'h100);

        // Start held high: operands captured once, DONE cycle launches the next op
        @(posedge clk); #2;
        a = 4'd5; b = 4'd2; cin = 1'b0; sub = 1'b0; start = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #2;
            if (i == 2) a = 4'd9;
            if (i == 5) begin
                chk("held_first_done", int'(done), 1);
                chk("held_first_s", int'(s), 7);
            end
            if (i == 10) begin
                chk("held_second_done", int'(done), 1);
                chk("held_second_s", int'(s), 11);
                start = 1'b0;
            end
        end
        repeat (3) @(posedge clk);

        // Reset mid-operation: immediate clear, no later done
        @(posedge clk); #2;
        a = 4'd6; b = 4'd6; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_s", int'(s), 0);
        q.delete();
        rem = 0; exp_busy = 1'b0; exp_done = 1'b0; last_s = 0; last_v = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (W + 3) @(posedge clk);
        op(1, 2, 1, 0, "after_rst", 5'b00100, -1);

        // Randomized traffic, including starts during RUN and operand changes mid-op
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #2;
            start = ($urandom_range(0, 2) == 0);
            a     = W'($urandom);
            b     = W'($urandom);
            cin   = 1'($urandom);
            sub   = 1'($urandom);
        end
        start = 1'b0;
        repeat (W + 3) @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
